// File: rtl/eth_arb_pkg.sv
// Shared types and sizing helpers for the Ethernet TX frame arbiter and its pickers.
package eth_arb_pkg;

   typedef enum logic [1:0] {IDLE, FWD, ABORT, DRAIN} state_t;

   localparam int STALL_CNT_W = 16;

   // A one-port pointer still needs a bit so the select logic stays well formed.
   function automatic int ptr_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/eth_tx_frame_arbiter_if.sv
// AXI-stream bundle between the frame sources, the arbiter and the MAC tx_axis input.
interface eth_tx_frame_arbiter_if #(
   parameter int N_PORTS    = 2,
   parameter int DATA_WIDTH = 8
);

   logic [N_PORTS*DATA_WIDTH-1:0] s_axis_tdata;
   logic [N_PORTS-1:0]            s_axis_tvalid;
   logic [N_PORTS-1:0]            s_axis_tready;
   logic [N_PORTS-1:0]            s_axis_tlast;
   logic [N_PORTS-1:0]            s_axis_tuser;
   logic [DATA_WIDTH-1:0]         m_axis_tdata;
   logic                          m_axis_tvalid;
   logic                          m_axis_tready;
   logic                          m_axis_tlast;
   logic                          m_axis_tuser;

   // Environment side: drives the sources and the MAC ready.
   modport master (
      output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
      input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
   );

   // Arbiter side.
   modport slave (
      input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
      output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
   );

endinterface

// File: rtl/eth_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module eth_rr_pick
   import eth_arb_pkg::*;
#(
   parameter int N_PORTS = 2,
   parameter int PTR_W   = ptr_w(N_PORTS)
) (
   input  logic [N_PORTS-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [N_PORTS-1:0] pick,
   output logic [PTR_W-1:0]   pick_idx
);

   logic found;

   always_comb begin
      pick     = '0;
      pick_idx = '0;
      found    = 1'b0;
      for (int k = 0; k < N_PORTS; k++) begin
         if (!found && req[(int'(ptr) + k) % N_PORTS]) begin
            found                                = 1'b1;
            pick[(int'(ptr) + k) % N_PORTS]      = 1'b1;
            pick_idx                             = PTR_W'((int'(ptr) + k) % N_PORTS);
         end
      end
   end

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing the MAC TX AXI-stream among N_PORTS sources.
// Optional stall watchdog (ABORT/DRAIN, stall_abort port) enabled by TX_ARB_WATCHDOG_EN.
//
// state | meaning
// IDLE  | no owner; sample requests, register one-hot grant
// FWD   | combinational pass-through of the granted source until its tlast is accepted
// ABORT | watchdog fired; emit one tlast+tuser beat so the MAC drops the frame
// DRAIN | sink the stalled source's remaining beats without forwarding
module eth_tx_frame_arbiter
   import eth_arb_pkg::*;
#(
   parameter int N_PORTS    = 2,
   parameter int DATA_WIDTH = 8
`ifdef TX_ARB_WATCHDOG_EN
   ,
   parameter int STALL_LIMIT = 1024
`endif
) (
   input  logic                 clk,
   input  logic                 rst,
   eth_tx_frame_arbiter_if.slave bus,
   output logic [N_PORTS-1:0]   arb_grant,
   output logic                 arb_busy
`ifdef TX_ARB_WATCHDOG_EN
   ,
   output logic                 stall_abort
`endif
);

   localparam int PTR_W = ptr_w(N_PORTS);

   state_t                  state;
   logic [PTR_W-1:0]        rr_ptr;
   logic [PTR_W-1:0]        g_idx;
   logic [PTR_W-1:0]        next_ptr;
   logic [N_PORTS-1:0]      pick;
   logic [PTR_W-1:0]        pick_idx;
   logic                    sel_valid;
   logic                    sel_last;
   logic                    sel_user;
   logic [DATA_WIDTH-1:0]   sel_data;
   logic                    frame_done;

   eth_rr_pick #(.N_PORTS(N_PORTS), .PTR_W(PTR_W)) u_pick (
      .req      (bus.s_axis_tvalid),
      .ptr      (rr_ptr),
      .pick     (pick),
      .pick_idx (pick_idx)
   );

   // Grant is one-hot or zero, so the mux collapses to zeros when idle.
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_user  = 1'b0;
      sel_data  = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         if (arb_grant[i]) begin
            sel_valid = bus.s_axis_tvalid[i];
            sel_last  = bus.s_axis_tlast[i];
            sel_user  = bus.s_axis_tuser[i];
            sel_data  = bus.s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign next_ptr = (g_idx == PTR_W'(N_PORTS - 1)) ? '0 : g_idx + PTR_W'(1);

`ifdef TX_ARB_WATCHDOG_EN
   logic [STALL_CNT_W-1:0] stall_cnt;

   assign frame_done = ((state == FWD) && sel_valid && bus.m_axis_tready && sel_last) ||
                       ((state == DRAIN) && ((sel_valid && sel_last) ||
                                             (!sel_valid && stall_cnt == STALL_CNT_W'(1))));
`else
   assign frame_done = (state == FWD) && sel_valid && bus.m_axis_tready && sel_last;
`endif

   always_comb begin
      bus.m_axis_tvalid = 1'b0;
      bus.m_axis_tdata  = '0;
      bus.m_axis_tlast  = 1'b0;
      bus.m_axis_tuser  = 1'b0;
      bus.s_axis_tready = '0;
      case (state)
         FWD: begin
            bus.m_axis_tvalid = sel_valid;
            bus.m_axis_tdata  = sel_data;
            bus.m_axis_tlast  = sel_last;
            bus.m_axis_tuser  = sel_user;
            bus.s_axis_tready = arb_grant & {N_PORTS{bus.m_axis_tready}};
         end
`ifdef TX_ARB_WATCHDOG_EN
         ABORT: begin
            bus.m_axis_tvalid = 1'b1;
            bus.m_axis_tlast  = 1'b1;
            bus.m_axis_tuser  = 1'b1;
         end
         DRAIN: bus.s_axis_tready = arb_grant;
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         g_idx     <= '0;
         arb_grant <= '0;
         arb_busy  <= 1'b0;
`ifdef TX_ARB_WATCHDOG_EN
         stall_cnt   <= '0;
         stall_abort <= 1'b0;
`endif
      end else begin
`ifdef TX_ARB_WATCHDOG_EN
         stall_abort <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (|bus.s_axis_tvalid) begin
                  state     <= FWD;
                  arb_grant <= pick;
                  g_idx     <= pick_idx;
                  arb_busy  <= 1'b1;
`ifdef TX_ARB_WATCHDOG_EN
                  stall_cnt <= STALL_CNT_W'(STALL_LIMIT);
`endif
               end
            end
`ifdef TX_ARB_WATCHDOG_EN
            // Down-counter: terminal count 1 means STALL_LIMIT idle cycles have elapsed.
            FWD: begin
               if (sel_valid && bus.m_axis_tready) begin
                  stall_cnt <= STALL_CNT_W'(STALL_LIMIT);
               end else if (!sel_valid) begin
                  if (stall_cnt == STALL_CNT_W'(1)) begin
                     state       <= ABORT;
                     stall_abort <= 1'b1;
                  end else begin
                     stall_cnt <= stall_cnt - STALL_CNT_W'(1);
                  end
               end
            end
            ABORT: begin
               if (bus.m_axis_tready) begin
                  state     <= DRAIN;
                  stall_cnt <= STALL_CNT_W'(STALL_LIMIT);
               end
            end
            DRAIN: begin
               if (sel_valid) stall_cnt <= STALL_CNT_W'(STALL_LIMIT);
               else           stall_cnt <= stall_cnt - STALL_CNT_W'(1);
            end
`endif
            default: ;
         endcase
         if (frame_done) begin
            state     <= IDLE;
            arb_grant <= '0;
            arb_busy  <= 1'b0;
            rr_ptr    <= next_ptr;
         end
      end
   end

endmodule
